fp16_div: RTL and testbench



---
 rtl/fp16_pkg.sv | 23 ++
 rtl/fp16_mant_divider.sv | 56 +++++
 rtl/fp16_div.sv | 143 ++++++++++++++
 tb/tb_fp16_div.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared constants, status bit positions and FSM encoding for the fp16 divider.
package fp16_pkg;

  localparam int MANT_W   = 10;
  localparam int EXP_W    = 5;
  localparam int EXP_BIAS = 15;
  localparam int QBITS    = 13;

  localparam logic [EXP_W-1:0] FP16_EXP_MAX = 5'h1F;
  localparam logic [15:0]      FP16_ZERO    = 16'h0000;

  // status = {div_by_zero, overflow, underflow}
  localparam int ST_DIV0 = 2;
  localparam int ST_OVF  = 1;
  localparam int ST_UNF  = 0;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_DIVIDE = 2'd1;
  localparam state_t S_NORM   = 2'd2;
  localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/fp16_mant_divider.sv
// Restoring mantissa divider: one quotient bit per cycle, QBITS cycles per start.
module fp16_mant_divider
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [MANT_W:0]   mx_i,
  input  logic [MANT_W:0]   my_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [QBITS-1:0]  q_o,
  output logic [MANT_W+1:0] r_o
);

  logic              busy_q;
  logic [3:0]        cnt_q;
  logic [QBITS-1:0]  q_q;
  logic [MANT_W+1:0] r_q;
  logic [MANT_W:0]   my_q;
  logic              r_ge;
  logic [MANT_W+1:0] r_sub;

  always_comb begin
    r_ge  = r_q >= {1'b0, my_q};
    r_sub = r_ge ? (r_q - {1'b0, my_q}) : r_q;
  end

  // done is high during the cycle that performs the last iteration
  assign done_o = busy_q && (cnt_q == 4'(QBITS - 1));
  assign busy_o = busy_q;
  assign q_o    = q_q;
  assign r_o    = r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      my_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= {1'b0, mx_i};
      my_q   <= my_i;
    end else if (busy_q) begin
      q_q   <= {q_q[QBITS-2:0], r_ge};
      r_q   <= r_sub << 1;
      cnt_q <= cnt_q + 4'd1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fp16_div.sv
// Iterative fp16 divider z = x / y with RNE rounding behind a valid/ready handshake.
module fp16_div
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] z,
  output logic [2:0]  status,
  output logic [1:0]  dbg_state_o,
  output logic        dbg_busy_o
);

  // Handshake: operands transfer on a cycle with in_valid & in_ready (only in
  // IDLE); the result transfers on out_valid & out_ready and is held until then.
  state_t            state_q, state_d;
  logic              sign_q;
  logic signed [6:0] e_q;
  logic [15:0]       z_q;
  logic [2:0]        status_q;

  logic              accept, special;
  logic              x_zero, x_inf, y_zero, y_inf;
  logic [15:0]       z_spec;
  logic [2:0]        st_spec;
  logic signed [6:0] e_base;

  logic              div_busy, div_done;
  logic [QBITS-1:0]  div_q;
  logic [MANT_W+1:0] div_r;

  logic [MANT_W-1:0] mant_t;
  logic              guard, sticky, round_up;
  logic [MANT_W:0]   mant_sum;
  logic signed [6:0] e_n, e_r;
  logic [15:0]       z_norm;
  logic [2:0]        st_norm;

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign accept      = in_valid & in_ready;
  assign z           = z_q;
  assign status      = status_q;
  assign dbg_state_o = state_q;
  assign dbg_busy_o  = div_busy;

  assign e_base = $signed({2'b00, x[14:10]}) - $signed({2'b00, y[14:10]})
                + $signed(7'(EXP_BIAS));

  // Subnormals flush to zero; exponent 31 is infinity regardless of mantissa
  always_comb begin
    x_zero  = (x[14:10] == '0);
    y_zero  = (y[14:10] == '0);
    x_inf   = (x[14:10] == FP16_EXP_MAX);
    y_inf   = (y[14:10] == FP16_EXP_MAX);
    special = x_zero | y_zero | x_inf | y_inf;
    z_spec  = FP16_ZERO;
    st_spec = '0;
    if (y_zero) begin
      z_spec           = {x[15] ^ y[15], FP16_EXP_MAX, {MANT_W{1'b0}}};
      st_spec[ST_DIV0] = 1'b1;
    end else if (x_inf) begin
      z_spec = {x[15] ^ y[15], FP16_EXP_MAX, {MANT_W{1'b0}}};
    end
  end

  fp16_mant_divider u_mant_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept & ~special),
    .mx_i    ({1'b1, x[MANT_W-1:0]}),
    .my_i    ({1'b1, y[MANT_W-1:0]}),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .q_o     (div_q),
    .r_o     (div_r)
  );

  // Quotient lies in (0.5, 2): q[12] selects which bit is the leading one
  always_comb begin
    if (div_q[QBITS-1]) begin
      mant_t = div_q[QBITS-2:2];
      guard  = div_q[1];
      sticky = div_q[0] | (|div_r);
      e_n    = e_q;
    end else begin
      mant_t = div_q[QBITS-3:1];
      guard  = div_q[0];
      sticky = |div_r;
      e_n    = e_q - 7'sd1;
    end
    round_up = guard & (sticky | mant_t[0]);
    mant_sum = {1'b0, mant_t} + {{MANT_W{1'b0}}, round_up};
    e_r      = e_n + (mant_sum[MANT_W] ? 7'sd1 : 7'sd0);
    z_norm   = {sign_q, e_r[EXP_W-1:0], mant_sum[MANT_W-1:0]};
    st_norm  = '0;
    if (e_r >= 7'sd31) begin
      z_norm          = {sign_q, FP16_EXP_MAX, {MANT_W{1'b0}}};
      st_norm[ST_OVF] = 1'b1;
    end else if (e_r <= 7'sd0) begin
      z_norm          = FP16_ZERO;
      st_norm[ST_UNF] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = special ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (div_done) state_d = S_NORM;
      S_NORM:   state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      e_q      <= '0;
      z_q      <= FP16_ZERO;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sign_q   <= x[15] ^ y[15];
        e_q      <= e_base;
        status_q <= special ? st_spec : 3'b000;
        if (special) z_q <= z_spec;
      end else if (state_q == S_NORM) begin
        z_q      <= z_norm;
        status_q <= st_norm;
      end
    end
  end

endmodule

// File: tb/tb_fp16_div.sv
// Self-checking bench for fp16_div: directed cases plus random operands vs a real-valued model.
module tb_fp16_div;
  import fp16_pkg::*;

  localparam int LAT_MAX = 40;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] x, y, z;
  logic [2:0]  status;
  logic [1:0]  dbg_state_o;
  logic        dbg_busy_o;

  int total = 0;
  int bad   = 0;
  logic [18:0] exp_q[$];

  fp16_div dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .status(status), .dbg_state_o(dbg_state_o), .dbg_busy_o(dbg_busy_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
    return (a[14:10] == 5'd0) || (a[14:10] == 5'd31) ||
           (b[14:10] == 5'd0) || (b[14:10] == 5'd31);
  endfunction

  // Reference: exact quotient in real arithmetic, then round-to-nearest-even to 10 bits
  function automatic logic [18:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int   ea, eb, e, mi;
    real  q, m, fr;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (eb == 0)  return {3'b100, s, 5'h1F, 10'h000};
    if (ea == 31) return {3'b000, s, 5'h1F, 10'h000};
    if (ea == 0 || eb == 31) return 19'h0;
    q = (1024.0 + real'(int'(a[9:0]))) / (1024.0 + real'(int'(b[9:0])));
    e = ea - eb + 15;
    if (q < 1.0) begin
      q = q * 2.0;
      e = e - 1;
    end
    m  = q * 1024.0;
    mi = int'($floor(m));
    fr = m - real'(mi);
    if (fr > 0.5 || (fr == 0.5 && mi[0])) mi = mi + 1;
    if (mi == 2048) begin
      mi = 1024;
      e  = e + 1;
    end
    if (e >= 31) return {3'b010, s, 5'h1F, 10'h000};
    if (e <= 0)  return {3'b001, 16'h0000};
    return {3'b000, s, e[4:0], mi[9:0]};
  endfunction

  // driver: issue one divide, check latency/result, optionally stall the consumer
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall);
    logic [18:0] exp_v;
    int lat, want_lat;
    out_ready = (stall == 0);
    check("in_ready_idle", in_ready, 1);
    x = a; y = b; in_valid = 1'b1;
    exp_q.push_back(ref_div(a, b));
    want_lat = is_special(a, b) ? 1 : 15;
    @(negedge clk);
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < LAT_MAX) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, want_lat);
    exp_v = exp_q.pop_front();
    check("z", z, exp_v[15:0]);
    check("status", status, exp_v[18:16]);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_z", z, exp_v[15:0]);
      check("hold_status", status, exp_v[18:16]);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  logic [15:0] dir_x [8] = '{16'h4600, 16'h3C00, 16'hBC00, 16'h3C00,
                             16'h0000, 16'h7BFF, 16'h0400, 16'h7C00};
  logic [15:0] dir_y [8] = '{16'h4000, 16'h4200, 16'h4000, 16'h0000,
                             16'h4000, 16'h3800, 16'h4000, 16'h4000};
  logic [15:0] dir_z [8] = '{16'h4200, 16'h3555, 16'hB800, 16'h7C00,
                             16'h0000, 16'h7C00, 16'h0000, 16'h7C00};
  logic [2:0]  dir_s [8] = '{3'b000, 3'b000, 3'b000, 3'b100,
                             3'b000, 3'b010, 3'b001, 3'b000};

  initial begin
    logic [15:0] a, b;
    logic [18:0] mv;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 16'h0000);
    check("rst_status", status, 3'b000);
    check("rst_state", dbg_state_o, S_IDLE);

    // model sanity on the hand-derived table, then the DUT on the same operands
    for (int i = 0; i < 8; i++) begin
      mv = ref_div(dir_x[i], dir_y[i]);
      check("model_z", mv[15:0], dir_z[i]);
      check("model_status", mv[18:16], dir_s[i]);
      run_op(dir_x[i], dir_y[i], 0);
    end

    // backpressure on 6.0/2.0
    run_op(16'h4600, 16'h4000, 5);

    // reset in the middle of a divide
    x = 16'h4600; y = 16'h4000; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_state", dbg_state_o, S_DIVIDE);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", dbg_state_o, S_IDLE);
    check("abort_out_valid", out_valid, 0);
    check("abort_z", z, 16'h0000);
    check("abort_status", status, 3'b000);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_result", seen, 0);
    run_op(16'h4600, 16'h4000, 0);

    // random operands, mostly in the normal range, random consumer stalls
    for (int n = 0; n < 150; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 9) != 0) a[14:10] = 5'($urandom_range(1, 30));
      if ($urandom_range(0, 9) != 0) b[14:10] = 5'($urandom_range(1, 30));
      run_op(a, b, $urandom_range(0, 3));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
